// File: rtl/program_loader.sv
// Collects a 128-byte program image from a byte stream, then commits it to the
// core's instruction-load bus and releases the core after a fixed reset hold.
module program_loader #(
    parameter int RST_HOLD = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic [1023:0] load_ins,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_RUN} state_t;

    state_t              state_reg, state_next;
    logic [6:0]          idx_reg;
    logic [1023:0]       shadow_reg, shadow_next;
    logic [1023:0]       load_ins_reg;
    logic [IDLE_W-1:0]   idle_cnt_reg;
    logic                first_seen_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic                err_reg;
    logic                done_reg;

    logic accept, begin_load, timeout_hit, last_byte, commit_load, hold_done;

    assign accept      = (state_reg == S_LOAD) && s_valid;
    assign begin_load  = start && (state_reg == S_IDLE || state_reg == S_RUN);
    // An accepted byte in the expiry cycle wins over the timeout.
    assign timeout_hit = (state_reg == S_LOAD) && first_seen_reg && !accept
                         && (idle_cnt_reg >= IDLE_W'(TIMEOUT - 1));
    assign last_byte   = accept && (idx_reg == 7'd127);
    assign commit_load = (state_reg == S_COMMIT) && (hold_cnt_reg == '0);
    assign hold_done   = (state_reg == S_COMMIT) && (hold_cnt_reg == HOLD_W'(RST_HOLD));

    // Per-byte shadow update: cleared on a new load, written when idx selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 128; gi++) begin : g_byte
            assign shadow_next[gi*8 +: 8] =
                begin_load                          ? 8'h00  :
                (accept && (idx_reg == 7'(gi)))     ? s_data :
                                                      shadow_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD: begin
                if (last_byte)        state_next = S_COMMIT;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_COMMIT: if (hold_done) state_next = S_RUN;
            S_RUN:    if (start) state_next = S_LOAD;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            shadow_reg     <= '0;
            load_ins_reg   <= '0;
            idle_cnt_reg   <= '0;
            first_seen_reg <= 1'b0;
            hold_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;

            if (begin_load)  idx_reg <= '0;
            else if (accept) idx_reg <= idx_reg + 7'd1;

            if (begin_load)  first_seen_reg <= 1'b0;
            else if (accept) first_seen_reg <= 1'b1;

            // Idle counter only runs once the first byte has arrived, and saturates.
            if (begin_load || accept)
                idle_cnt_reg <= '0;
            else if (state_reg == S_LOAD && first_seen_reg
                     && idle_cnt_reg < IDLE_W'(TIMEOUT))
                idle_cnt_reg <= idle_cnt_reg + 1'b1;

            if (state_reg == S_COMMIT && state_next == S_COMMIT)
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            else
                hold_cnt_reg <= '0;

            if (commit_load) load_ins_reg <= shadow_reg;

            if (timeout_hit)                         err_reg <= 1'b1;
            else if (start && state_reg == S_IDLE)   err_reg <= 1'b0;

            done_reg <= hold_done;
        end
    end

    assign s_ready    = (state_reg == S_LOAD);
    assign core_reset = (state_reg != S_RUN);
    assign busy       = (state_reg == S_LOAD) || (state_reg == S_COMMIT);
    assign done       = done_reg;
    assign err        = err_reg;
    assign load_ins   = load_ins_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full loads, gapped stream, reload,
// timeout boundary, reset mid-load and overrun.
module tb_program_loader;

    logic          clk = 1'b0;
    logic          reset, start, s_valid;
    logic [7:0]    s_data;
    logic          s_ready, core_reset, busy, done, err;
    logic [1023:0] load_ins;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1023:0] img_seq, img_aa;

    program_loader #(.RST_HOLD(4), .TIMEOUT(1000)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .load_ins(load_ins),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s", tag);
        end
    endtask

    // Feed n bytes (value = byte index, or 0xAA); optional 1/0 valid toggling
    // and a start pulse held while byte start_at is outstanding.
    task automatic load_bytes(input int n, input bit gaps, input bit aa,
                              input int start_at, output int hs);
        int cyc = 0;
        bit ph = 1'b0;
        hs = 0;
        while (hs < n && cyc < 2000) begin
            s_valid = gaps ? ph : 1'b1;
            ph      = ~ph;
            s_data  = aa ? 8'hAA : 8'(hs);
            start   = (start_at >= 0) && (hs == start_at);
            if (s_valid && s_ready) hs++;
            step();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) check("load_budget", 1'b0, 1'b1);
    endtask

    // Entered on the first COMMIT cycle, right after byte 127 was accepted.
    task automatic commit_check(input string tag, input logic [1023:0] exp_img,
                                input logic [1023:0] prev_img);
        int extra = 0, hold = 0, dones = 0, cyc = 0;
        check({tag, "_sready_drop"}, s_ready, 1'b0);
        check({tag, "_busy_commit"}, busy, 1'b1);
        check({tag, "_img_before"}, load_ins, prev_img);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        start   = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_img"}, load_ins, exp_img);
        while (core_reset && cyc < 50) begin
            if (s_valid && s_ready) extra++;
            if (done) dones++;
            hold++;
            step();
            cyc++;
        end
        check({tag, "_hold_cycles"}, 32'(hold), 32'd4);
        check({tag, "_done_early"}, 32'(dones), 32'd0);
        check({tag, "_done_pulse"}, done, 1'b1);
        check({tag, "_busy_run"}, busy, 1'b0);
        step();
        check({tag, "_done_once"}, done, 1'b0);
        check({tag, "_overrun"}, 32'(extra), 32'd0);
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        for (int i = 0; i < 128; i++) img_seq[8*i +: 8] = 8'(i);
        img_aa = {128{8'hAA}};

        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        step(); step();
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_load_ins", load_ins, '0);
        reset = 1'b0;
        step();

        // Full load with a start pulse mid-load that must be ignored.
        start = 1'b1; step(); start = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_s_ready", s_ready, 1'b1);
        check("load_core_reset", core_reset, 1'b1);
        load_bytes(128, 1'b0, 1'b0, 50, hs);
        commit_check("full", img_seq, '0);
        check("full_word0", load_ins[31:0], 32'h03020100);
        check("full_word31", load_ins[1023:992], 32'h7F7E7D7C);

        // Reload from RUN with all-0xAA image.
        start = 1'b1; step(); start = 1'b0;
        check("reload_core_reset", core_reset, 1'b1);
        load_bytes(128, 1'b0, 1'b1, -1, hs);
        commit_check("aa", img_aa, img_seq);

        // Gapped stream: valid toggles every cycle.
        start = 1'b1; step(); start = 1'b0;
        load_bytes(128, 1'b1, 1'b0, -1, hs);
        check("gaps_handshakes", 32'(hs), 32'd128);
        check("gaps_err", err, 1'b0);
        commit_check("gaps", img_seq, img_aa);

        // No timeout before the first byte.
        start = 1'b1; step(); start = 1'b0;
        s_valid = 1'b0;
        repeat (1200) step();
        check("wait_busy", busy, 1'b1);
        check("wait_err", err, 1'b0);

        // Timeout: a byte in the expiry cycle wins; then a full TIMEOUT idle.
        load_bytes(10, 1'b0, 1'b0, -1, hs);
        s_valid = 1'b0;
        repeat (999) step();
        load_bytes(1, 1'b0, 1'b0, -1, hs);
        check("collide_err", err, 1'b0);
        check("collide_busy", busy, 1'b1);
        s_valid = 1'b0;
        repeat (999) step();
        check("to_edge_err", err, 1'b0);
        check("to_edge_busy", busy, 1'b1);
        step();
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_s_ready", s_ready, 1'b0);
        check("to_core_reset", core_reset, 1'b1);
        check("to_load_ins", load_ins, img_seq);

        // IDLE->LOAD clears err.
        start = 1'b1; step(); start = 1'b0;
        check("err_clear", err, 1'b0);
        check("err_clear_busy", busy, 1'b1);

        // Reset mid-load at byte 64, colliding with start and a valid byte.
        load_bytes(64, 1'b0, 1'b0, -1, hs);
        reset = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        step();
        check("mid_rst_load_ins", load_ins, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_s_ready", s_ready, 1'b0);
        check("mid_rst_core_reset", core_reset, 1'b1);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        reset = 1'b0; start = 1'b0; s_valid = 1'b0;
        step();

        start = 1'b1; step(); start = 1'b0;
        load_bytes(128, 1'b0, 1'b0, -1, hs);
        commit_check("after_rst", img_seq, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter RST_HOLD, default 4: cycles core_reset stays high after a new image is committed, minimum 1.
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum idle cycles allowed between accepted bytes during a load, minimum 2.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a new program load.
REQ-006 SHALL have port s_valid  input  1  byte-stream valid.
REQ-007 SHALL have port s_data  input  8  byte-stream payload.
REQ-008 SHALL have port s_ready  output  1  byte-stream ready; a byte is accepted when s_valid and s_ready are both high.
REQ-009 SHALL have port load_ins  output  1024  committed program image driven to the core's instruction-load bus.
REQ-010 SHALL have port core_reset  output  1  reset for the core datapath, active-high.
REQ-011 SHALL have port busy  output  1  high in LOAD and COMMIT.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the core is released.
REQ-013 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, COMMIT, RUN.
REQ-015 IDLE: s_ready=0, core_reset=1; start=1 -> LOAD and clear err next cycle.
REQ-016 LOAD: s_ready=1, core_reset=1; each accepted byte is written to a 1024-bit shadow buffer at byte index idx (0..127), then idx increments.
REQ-017 Byte packing SHALL be little-endian: byte idx goes to shadow bits [8*idx+7 : 8*idx], so word k = bytes 4k..4k+3 and sits at load_ins[32k+31:32k]; word 0 is at address 0.
REQ-018 On acceptance of byte 127, the next state SHALL be COMMIT and s_ready SHALL drop the following cycle; no 129th byte is accepted.
REQ-019 On entry to LOAD, idx SHALL be 0 and the shadow buffer SHALL be cleared.
REQ-020 Bytes presented in IDLE, COMMIT or RUN SHALL NOT be accepted.
REQ-021 COMMIT, first cycle: load_ins <= shadow. core_reset SHALL stay 1 for RST_HOLD cycles counted from the cycle load_ins changes, then the FSM goes to RUN.
REQ-022 RUN: core_reset=0, s_ready=0; done=1 for exactly the first RUN cycle.
REQ-023 start in RUN -> LOAD, and core_reset=1 from the next cycle on.
REQ-024 start SHALL be ignored in LOAD and COMMIT.
REQ-025 load_ins SHALL change only in the COMMIT first cycle; an aborted load leaves it at its previous value.
REQ-026 Timeout: an idle counter runs in LOAD after the first accepted byte, clears on each accepted byte, and saturates. On reaching TIMEOUT cycles with no accepted byte: err<=1, FSM -> IDLE, core_reset stays 1.
REQ-027 Before the first byte of a load, LOAD SHALL wait indefinitely with no timeout.
REQ-028 err SHALL clear only on reset or on the IDLE->LOAD transition.
REQ-029 If an accepted byte and the timeout expiry fall in the same cycle, the byte SHALL win and the counter clears.
REQ-030 busy SHALL equal (state==LOAD || state==COMMIT).

Reset
REQ-031 reset=1 SHALL force: state IDLE, load_ins=0, shadow=0, idx=0, counters=0, core_reset=1, s_ready=0, busy=0, done=0, err=0.
REQ-032 reset SHALL take priority over start and over byte acceptance in the same cycle; reset mid-load discards all partial data.

Verification
REQ-033 Full load: start, then 128 bytes 0x00..0x7F with s_valid held high -> load_ins[31:0]=0x03020100, load_ins[1023:992]=0x7F7E7D7C; core_reset low 4 cycles after commit; done pulses once.
REQ-034 Backpressure/gaps: s_valid toggles 1/0 each cycle for 128 bytes with TIMEOUT=1000 -> no err, image correct, exactly 128 handshakes counted.
REQ-035 Timeout: 10 bytes then s_valid=0 for TIMEOUT cycles -> err=1, state IDLE, load_ins unchanged from the prior image, core_reset=1.
REQ-036 Reload from RUN: a second start after a completed load -> core_reset=1 the next cycle; a new image of all bytes 0xAA commits as 0xAAAAAAAA in every word.
REQ-037 Reset mid-load at byte 64 -> all outputs at reset values next cycle; a later full load produces the correct image.
REQ-038 Overrun: s_valid held high past byte 127 -> s_ready low after byte 127, byte 128 not consumed; start pulses during LOAD have no effect.
